// File: rtl/draw_cursor_if.sv
// vga_if: one VGA pixel stream (counters, syncs, blanking, 12-bit RGB).
//   in  modport - consumer view (all fields are inputs)
//   out modport - producer view (all fields are outputs)
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_cursor.sv
// draw_cursor: overlays a 16x16 arrow sprite at the mouse position on a VGA
// stream. The position is latched on each vblnk rising edge so the cursor
// never tears. All stream fields pass through a fixed 2-cycle pipeline.
//
// Ports:
//   clk40MHz  pixel clock
//   rst       asynchronous reset, active-low
//   in_if     synchronized input stream (vga_if.in)
//   out_if    overlaid output stream (vga_if.out), registered
//   xpos/ypos mouse position, already synchronous to clk40MHz
//
// Optional feature: define CURSOR_BLINK_EN to blink the cursor, toggling
// visibility every BLINK_FRAMES frames. Without it the cursor is always shown.
module draw_cursor #(
    parameter logic [11:0] CURSOR_RGB   = 12'hFFF,
    parameter logic [11:0] OUTLINE_RGB  = 12'h000,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk40MHz,
    input  logic        rst,
    vga_if.in           in_if,
    vga_if.out          out_if,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos
);

    typedef enum logic [1:0] {
        PX_CLEAR   = 2'd0,
        PX_OUTLINE = 2'd1,
        PX_FILL    = 2'd2
    } px_t;

    if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
        $error("draw_cursor: BLINK_FRAMES must be at least 1");
    end

    // Arrow sprite: a right triangle over rows 0..10 with a one-pixel outline
    // on the left edge and on the diagonal; rows 11..15 are empty.
    function automatic px_t sprite(input logic [3:0] r, input logic [3:0] c);
        px_t p;
        p = PX_CLEAR;
        if (r <= 4'd10) begin
            if (c == 4'd0 || c == r) p = PX_OUTLINE;
            else if (c < r)          p = PX_FILL;
        end
        return p;
    endfunction

    // ---------------- position latch ----------------
    logic        vblnk_d;
    logic [11:0] cur_x;
    logic [11:0] cur_y;
    logic        vblnk_rise;

    assign vblnk_rise = in_if.vblnk & ~vblnk_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk40MHz or negedge rst) begin
        if (!rst) begin
            vblnk_d <= 1'b0;
            cur_x   <= '0;
            cur_y   <= '0;
        end else begin
            vblnk_d <= in_if.vblnk;
            if (vblnk_rise) begin
                cur_x <= xpos;
                cur_y <= ypos;
            end
        end
    end

    // ---------------- blink control ----------------
    logic visible;
`ifdef CURSOR_BLINK_EN
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [CW-1:0] blink_cnt;

    always_ff @(posedge clk40MHz or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            visible   <= 1'b1;
        end else if (vblnk_rise) begin
            if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                visible   <= ~visible;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    assign visible = 1'b1;
`endif

    // ---------------- stage 1: window test ----------------
    // 13-bit compare so cur+16 cannot wrap; hcount is at most 2047, so any
    // position at or above 2048 simply never matches.
    logic [12:0] h13, v13, cx13, cy13;
    logic        inwin;

    assign h13   = {2'b00, in_if.hcount};
    assign v13   = {2'b00, in_if.vcount};
    assign cx13  = {1'b0, cur_x};
    assign cy13  = {1'b0, cur_y};
    assign inwin = (h13 >= cx13) && (h13 < cx13 + 13'd16) &&
                   (v13 >= cy13) && (v13 < cy13 + 13'd16);

    logic [10:0] hcount_s1, vcount_s1;
    logic        hsync_s1, vsync_s1, hblnk_s1, vblnk_s1, inwin_s1;
    logic [11:0] rgb_s1;
    logic [3:0]  dx_s1, dy_s1;

    always_ff @(posedge clk40MHz or negedge rst) begin
        if (!rst) begin
            hcount_s1 <= '0;
            vcount_s1 <= '0;
            hsync_s1  <= 1'b0;
            vsync_s1  <= 1'b0;
            hblnk_s1  <= 1'b0;
            vblnk_s1  <= 1'b0;
            rgb_s1    <= '0;
            inwin_s1  <= 1'b0;
            dx_s1     <= '0;
            dy_s1     <= '0;
        end else begin
            hcount_s1 <= in_if.hcount;
            vcount_s1 <= in_if.vcount;
            hsync_s1  <= in_if.hsync;
            vsync_s1  <= in_if.vsync;
            hblnk_s1  <= in_if.hblnk;
            vblnk_s1  <= in_if.vblnk;
            rgb_s1    <= in_if.rgb;
            inwin_s1  <= inwin;
            // Low 4 bits of the offset only depend on the low 4 bits.
            dx_s1     <= in_if.hcount[3:0] - cur_x[3:0];
            dy_s1     <= in_if.vcount[3:0] - cur_y[3:0];
        end
    end

    // ---------------- stage 2: colour mux ----------------
    px_t         px;
    logic [11:0] rgb_mix;

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        px      = sprite(dy_s1, dx_s1);
        rgb_mix = rgb_s1;
        if (inwin_s1 && !hblnk_s1 && !vblnk_s1 && visible) begin
            case (px)
                PX_OUTLINE: rgb_mix = OUTLINE_RGB;
                PX_FILL:    rgb_mix = CURSOR_RGB;
                default:    rgb_mix = rgb_s1;
            endcase
        end
    end

    always_ff @(posedge clk40MHz or negedge rst) begin
        if (!rst) begin
            out_if.hcount <= '0;
            out_if.vcount <= '0;
            out_if.hsync  <= 1'b0;
            out_if.vsync  <= 1'b0;
            out_if.hblnk  <= 1'b0;
            out_if.vblnk  <= 1'b0;
            out_if.rgb    <= '0;
        end else begin
            out_if.hcount <= hcount_s1;
            out_if.vcount <= vcount_s1;
            out_if.hsync  <= hsync_s1;
            out_if.vsync  <= vsync_s1;
            out_if.hblnk  <= hblnk_s1;
            out_if.vblnk  <= vblnk_s1;
            out_if.rgb    <= rgb_mix;
        end
    end

endmodule
